mac_accum_n: RTL and testbench

Downstream consumer of the registered N-bit multiplier. It accumulates a sequence of LEN products (2N bits each) into a wide accumulator to form a dot product. A start/busy/done handshake frames each run. Overflow is flagged, and saturation is optional.

---
 rtl/mac_pkg.sv | 16 +
 rtl/sat_add_n.sv | 27 ++
 rtl/mac_accum_n.sv | 98 +++++++++
 tb/tb_mac_accum_n.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared FSM encoding and width helper for the MAC accumulator.
// Included by mac_accum_n and sat_add_n.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Accumulator width: full product width plus guard bits.
  function automatic int acc_width(input int n, input int g);
    return 2 * n + g;
  endfunction

endpackage

// File: rtl/sat_add_n.sv
// Unsigned adder with carry out; clamps to all-ones on carry
// when MAC_SATURATE_EN is defined, otherwise wraps.
module sat_add_n
  import mac_pkg::*;
#(
  parameter int W = 20
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] w_full;

  // Full-width add exposes the carry out of bit W-1.
  always_comb begin
    w_full = {1'b0, a} + {1'b0, b};
    carry  = w_full[W];
`ifdef MAC_SATURATE_EN
    sum = w_full[W] ? {W{1'b1}} : w_full[W-1:0];
`else
    sum = w_full[W-1:0];
`endif
  end

endmodule

// File: rtl/mac_accum_n.sv
// Dot-product accumulator framed by start/busy/done.
// Optional clamping on overflow via MAC_SATURATE_EN.
module mac_accum_n
  import mac_pkg::*;
#(
  parameter int N   = 8,
  parameter int G   = 4,
  parameter int LEN = 16,
  localparam int ACC_W = acc_width(N, G),
  localparam int CW    = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2*N-1:0]   p,
  input  logic             p_valid,
  output logic [ACC_W-1:0] acc,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;

  logic [ACC_W-1:0] w_p_ext;
  logic [ACC_W-1:0] w_sum;
  logic             w_carry;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_last;

  assign w_p_ext   = ACC_W'(p);
  assign w_cnt_nxt = r_count + CW'(1);
  assign w_last    = (w_cnt_nxt == CW'(LEN));

  sat_add_n #(.W(ACC_W)) u_add (
    .a     (r_acc),
    .b     (w_p_ext),
    .sum   (w_sum),
    .carry (w_carry)
  );

  // FSM: start clears and (re)arms; accepted terms accumulate.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_state <= ACCUM;
        r_acc   <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          ACCUM: begin
            if (p_valid) begin
              r_acc   <= w_sum;
              r_count <= w_cnt_nxt;
              if (w_carry) r_ovf <= 1'b1;
              if (w_last) begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign acc      = r_acc;
  assign count    = r_count;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_mac_accum_n.sv
// Scoreboard bench for mac_accum_n: three instances
// (LEN=4/G=4, LEN=2/G=0, LEN=1/G=4).
module tb_mac_accum_n;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        st_a, pv_a, st_b, pv_b, st_c, pv_c;
  logic [15:0] p_a, p_b, p_c;

  logic [19:0] acc_a, acc_c;
  logic [15:0] acc_b;
  logic [2:0]  cnt_a;
  logic [1:0]  cnt_b;
  logic        cnt_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        ovf_a, ovf_b, ovf_c;

  mac_accum_n #(.N(8), .G(4), .LEN(4)) dut_a (
    .clk(clk), .reset(reset), .start(st_a), .p(p_a),
    .p_valid(pv_a), .acc(acc_a), .count(cnt_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a));

  mac_accum_n #(.N(8), .G(0), .LEN(2)) dut_b (
    .clk(clk), .reset(reset), .start(st_b), .p(p_b),
    .p_valid(pv_b), .acc(acc_b), .count(cnt_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b));

  mac_accum_n #(.N(8), .G(4), .LEN(1)) dut_c (
    .clk(clk), .reset(reset), .start(st_c), .p(p_c),
    .p_valid(pv_c), .acc(acc_c), .count(cnt_c),
    .busy(busy_c), .done(done_c), .overflow(ovf_c));

  typedef struct {
    logic [19:0] acc;
    int          cnt;
    logic        ovf;
  } exp_t;

  exp_t q_a[$], q_b[$], q_c[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input string nm, ref exp_t q[$],
                         input logic [19:0] a, input int c,
                         input logic o);
    exp_t e;
    if (q.size() == 0) begin
      check({nm, "_unexpected_done"}, 1, 0);
    end else begin
      e = q.pop_front();
      check({nm, "_acc"}, 64'(a), 64'(e.acc));
      check({nm, "_count"}, 64'(c), 64'(e.cnt));
      check({nm, "_ovf"}, 64'(o), 64'(e.ovf));
    end
  endtask

  // Monitors: every done pulse must match the next queued result.
  always @(negedge clk) if (!reset && done_a)
    pop_cmp("A", q_a, acc_a, int'(cnt_a), ovf_a);
  always @(negedge clk) if (!reset && done_b)
    pop_cmp("B", q_b, 20'(acc_b), int'(cnt_b), ovf_b);
  always @(negedge clk) if (!reset && done_c)
    pop_cmp("C", q_c, acc_c, int'(cnt_c), ovf_c);

  // Drive one cycle on instance d; others idle.
  task automatic drv(input int d, input logic s,
                     input logic [15:0] pp, input logic v);
    st_a = 0; pv_a = 0; p_a = 0;
    st_b = 0; pv_b = 0; p_b = 0;
    st_c = 0; pv_c = 0; p_c = 0;
    case (d)
      0: begin st_a = s; p_a = pp; pv_a = v; end
      1: begin st_b = s; p_b = pp; pv_b = v; end
      default: begin st_c = s; p_c = pp; pv_c = v; end
    endcase
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [19:0] a, input int c,
                              input logic o);
    exp_t e;
    e.acc = a; e.cnt = c; e.ovf = o;
    return e;
  endfunction

  initial begin
    reset = 1'b1;
    drv(0, 0, 0, 0);
    drv(0, 0, 0, 0);
    check("rst_acc_a", 64'(acc_a), 0);
    check("rst_cnt_a", 64'(cnt_a), 0);
    check("rst_flags_a", {busy_a, done_a, ovf_a}, 0);
    check("rst_b", {acc_b, busy_b, done_b, ovf_b}, 0);
    check("rst_c", {acc_c, busy_c, done_c, ovf_c}, 0);
    reset = 1'b0;
    drv(0, 0, 0, 0);

    // 1: four max products
    q_a.push_back(mk(20'h3F804, 4, 0));
    drv(0, 1, 0, 0);
    check("t1_busy", 64'(busy_a), 1);
    repeat (4) drv(0, 0, 16'hFE01, 1);
    check("t1_busy_done", {busy_a, done_a}, 2'b01);
    drv(0, 0, 0, 0);
    check("t1_done_width", 64'(done_a), 0);
    check("t1_hold", 64'(acc_a), 64'h3F804);

    // 2: gaps; IDLE terms ignored
    drv(0, 0, 100, 1);
    drv(0, 0, 100, 1);
    check("t2_idle_ign", 64'(acc_a), 64'h3F804);
    q_a.push_back(mk(20'd24, 4, 0));
    drv(0, 1, 0, 0);
    drv(0, 0, 3, 1);
    drv(0, 0, 5, 1);
    drv(0, 0, 77, 0);
    drv(0, 0, 77, 0);
    check("t2_busy_gap", 64'(busy_a), 1);
    check("t2_gap_acc", 64'(acc_a), 8);
    drv(0, 0, 7, 1);
    drv(0, 0, 77, 0);
    check("t2_busy_gap2", 64'(busy_a), 1);
    drv(0, 0, 9, 1);
    drv(0, 0, 0, 0);

    // 3: overflow on G=0, LEN=2
    q_b.push_back(mk(
`ifdef MAC_SATURATE_EN
      20'h0FFFF,
`else
      20'h0FC02,
`endif
      2, 1));
    drv(1, 1, 0, 0);
    drv(1, 0, 16'hFE01, 1);
    check("t3_no_ovf_yet", 64'(ovf_b), 0);
    drv(1, 0, 16'hFE01, 1);
    drv(1, 0, 0, 0);

    // 4: restart mid-run; term with start dropped
    q_a.push_back(mk(20'd10, 4, 0));
    drv(0, 1, 0, 0);
    drv(0, 0, 20, 1);
    drv(0, 0, 20, 1);
    check("t4_cnt2", 64'(cnt_a), 2);
    drv(0, 1, 50, 1);
    check("t4_restart", {acc_a, cnt_a}, 0);
    drv(0, 0, 1, 1);
    drv(0, 0, 2, 1);
    drv(0, 0, 3, 1);
    drv(0, 0, 4, 1);
    drv(0, 0, 0, 0);

    // 5: reset mid-run, then clean run
    drv(0, 1, 0, 0);
    drv(0, 0, 10, 1);
    drv(0, 0, 20, 1);
    drv(0, 0, 30, 1);
    reset = 1'b1;
    drv(0, 0, 40, 1);
    reset = 1'b0;
    check("t5_rst_acc", 64'(acc_a), 0);
    check("t5_rst_cnt", 64'(cnt_a), 0);
    check("t5_rst_flags", {busy_a, done_a, ovf_a}, 0);
    drv(0, 0, 0, 0);
    q_a.push_back(mk(20'd6, 4, 0));
    drv(0, 1, 0, 0);
    drv(0, 0, 1, 1);
    drv(0, 0, 1, 1);
    drv(0, 0, 2, 1);
    drv(0, 0, 2, 1);
    drv(0, 0, 0, 0);

    // start taken in DONE: pulse still seen, new run follows
    q_a.push_back(mk(20'd4, 4, 0));
    q_a.push_back(mk(20'd8, 4, 0));
    drv(0, 1, 0, 0);
    repeat (4) drv(0, 0, 1, 1);
    drv(0, 1, 0, 0);
    check("t5_restart_busy", 64'(busy_a), 1);
    repeat (4) drv(0, 0, 2, 1);
    drv(0, 0, 0, 0);

    // 6: LEN=1
    q_c.push_back(mk(20'h01234, 1, 0));
    drv(2, 1, 0, 0);
    drv(2, 0, 16'h1234, 1);
    check("t6_done", {busy_c, done_c}, 2'b01);
    repeat (10) drv(2, 0, 5, 1);
    check("t6_hold", 64'(acc_c), 64'h01234);
    drv(2, 1, 0, 0);
    check("t6_clear", {acc_c, busy_c}, 1);
    drv(2, 0, 0, 0);

    check("q_a_empty", 64'(q_a.size()), 0);
    check("q_b_empty", 64'(q_b.size()), 0);
    check("q_c_empty", 64'(q_c.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
